// File: rtl/hdr_pkg.sv
// Shared constants and FSM state type for the HDR pixel packer.
package hdr_pkg;

  localparam int unsigned PIXEL_W          = 16;
  localparam int unsigned PIXELS_PER_WORD  = 8;
  localparam int unsigned HDR_WORD_W       = PIXEL_W * PIXELS_PER_WORD;
  localparam int unsigned PIX_IDX_W        = $clog2(PIXELS_PER_WORD);
  localparam int unsigned FRAME_WORDS_DEF  = 38400;
  localparam int unsigned DONE_DELAY_DEF   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StPack,
    StDoneWait
  } pack_state_e;

endpackage

// File: rtl/hdr_word_assembler.sv
// Lane register for the packer: writes pixels into successive lanes and flags the
// pixel that completes a word, presenting that full word combinationally.
module hdr_word_assembler
  import hdr_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  wr_i,
  input  logic [PIXEL_W-1:0]    pixel_i,
  output logic [HDR_WORD_W-1:0] word_o,
  output logic                  complete_o,
  output logic [PIX_IDX_W-1:0]  pix_idx_o
);

  logic [PIXEL_W-1:0]   lanes_q [PIXELS_PER_WORD];
  logic [PIX_IDX_W-1:0] idx_q;

  // A write alongside clear is the first pixel of a fresh word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      for (int i = 0; i < PIXELS_PER_WORD; i++) begin
        lanes_q[i] <= '0;
      end
    end else if (clear_i) begin
      idx_q <= wr_i ? PIX_IDX_W'(1) : '0;
      if (wr_i) begin
        lanes_q[0] <= pixel_i;
      end
    end else if (wr_i) begin
      lanes_q[idx_q] <= pixel_i;
      idx_q          <= idx_q + PIX_IDX_W'(1);
    end
  end

  always_comb begin
    word_o = '0;
    for (int i = 0; i < PIXELS_PER_WORD - 1; i++) begin
      word_o[i*PIXEL_W +: PIXEL_W] = lanes_q[i];
    end
    word_o[HDR_WORD_W-1 -: PIXEL_W] = pixel_i;
  end

  assign complete_o = wr_i && !clear_i && (idx_q == PIX_IDX_W'(PIXELS_PER_WORD - 1));
  assign pix_idx_o  = idx_q;

endmodule

// File: rtl/hdr_pixel_packer.sv
// Packs 8 HDR pixels per 128-bit word for the store stage, counts words per frame
// and issues delayed frame_done / frame_abort pulses.
module hdr_pixel_packer
  import hdr_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned DONE_DELAY  = DONE_DELAY_DEF
) (
  input  logic                  clk_25M,
  input  logic                  rst_25M,
  input  logic                  frame_start,
  input  logic [PIXEL_W-1:0]    pixel_data,
  input  logic                  pixel_valid,
  output logic [HDR_WORD_W-1:0] hdr_data,
  output logic                  hdr_data_valid,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned DlyW = $clog2(DONE_DELAY + 1);

  pack_state_e           state_q, state_d;
  logic [CntW-1:0]       word_cnt_q, word_cnt_d;
  logic [DlyW-1:0]       dly_q, dly_d;
  logic [HDR_WORD_W-1:0] hdr_data_q, hdr_data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;

  logic                  asm_clear, asm_wr, asm_complete;
  logic [HDR_WORD_W-1:0] asm_word;
  logic [PIX_IDX_W-1:0]  asm_idx;

  // frame_start restarts the lanes in every state; a coincident pixel becomes lane 0.
  assign asm_clear = frame_start;
  assign asm_wr    = pixel_valid && (frame_start || (state_q == StPack));

  hdr_word_assembler u_assembler (
    .clk_i      (clk_25M),
    .rst_i      (rst_25M),
    .clear_i    (asm_clear),
    .wr_i       (asm_wr),
    .pixel_i    (pixel_data),
    .word_o     (asm_word),
    .complete_o (asm_complete),
    .pix_idx_o  (asm_idx)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    dly_d      = dly_q;
    hdr_data_d = hdr_data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d    = StPack;
          word_cnt_d = '0;
          dly_d      = '0;
        end
      end
      StPack: begin
        if (frame_start) begin
          abort_d    = (word_cnt_q != '0) || (asm_idx != '0);
          word_cnt_d = '0;
          dly_d      = '0;
        end else if (asm_complete) begin
          hdr_data_d = asm_word;
          valid_d    = 1'b1;
          word_cnt_d = word_cnt_q + CntW'(1);
          if (word_cnt_q == CntW'(FRAME_WORDS - 1)) begin
            state_d = StDoneWait;
            dly_d   = '0;
          end
        end
      end
      StDoneWait: begin
        if (frame_start) begin
          state_d    = StPack;
          word_cnt_d = '0;
          dly_d      = '0;
        end else if (dly_q == DlyW'(DONE_DELAY - 1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          dly_d = dly_q + DlyW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_25M) begin
    if (rst_25M) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      dly_q      <= '0;
      hdr_data_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      dly_q      <= dly_d;
      hdr_data_q <= hdr_data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  assign hdr_data       = hdr_data_q;
  assign hdr_data_valid = valid_q;
  assign frame_done     = done_q;
  assign frame_abort    = abort_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_hdr_pixel_packer.sv
// Directed bench for hdr_pixel_packer with a 4-word frame and 4-cycle done delay.
module tb_hdr_pixel_packer;

  logic         clk_25M = 1'b0;
  logic         rst_25M = 1'b1;
  logic         frame_start = 1'b0;
  logic [15:0]  pixel_data = '0;
  logic         pixel_valid = 1'b0;
  logic [127:0] hdr_data;
  logic         hdr_data_valid;
  logic         frame_done;
  logic         frame_abort;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int           s_cyc[$];
  logic [127:0] s_dat[$];
  int           d_cyc[$];
  int           a_cyc[$];

  hdr_pixel_packer #(
    .FRAME_WORDS (4),
    .DONE_DELAY  (4)
  ) dut (
    .clk_25M        (clk_25M),
    .rst_25M        (rst_25M),
    .frame_start    (frame_start),
    .pixel_data     (pixel_data),
    .pixel_valid    (pixel_valid),
    .hdr_data       (hdr_data),
    .hdr_data_valid (hdr_data_valid),
    .frame_done     (frame_done),
    .frame_abort    (frame_abort),
    .busy           (busy)
  );

  initial forever #5 clk_25M = ~clk_25M;

  always @(posedge clk_25M) cyc <= cyc + 1;

  // Each output pulse is logged once per high cycle, so a stretched pulse shows as two entries.
  always @(negedge clk_25M) begin
    if (hdr_data_valid) begin
      s_cyc.push_back(cyc);
      s_dat.push_back(hdr_data);
    end
    if (frame_done) d_cyc.push_back(cyc);
    if (frame_abort) a_cyc.push_back(cyc);
  end

  task automatic step(input logic fs, input logic pv, input logic [15:0] pd);
    frame_start = fs;
    pixel_valid = pv;
    pixel_data  = pd;
    @(posedge clk_25M);
    #1;
  endtask

  task automatic do_reset();
    rst_25M = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    rst_25M = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (hdr_data !== 128'h0) begin errors++;
      $display("FAIL reset_hdr_data: got %h want 0", hdr_data); end
    checks++; if (hdr_data_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0", hdr_data_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++;
      $display("FAIL reset_done: got %b want 0", frame_done); end
    checks++; if (frame_abort !== 1'b0) begin errors++;
      $display("FAIL reset_abort: got %b want 0", frame_abort); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_word();
    int sb;
    int c8;
    logic [127:0] exp;
    exp = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    do_reset();
    sb = s_cyc.size();
    step(1'b1, 1'b0, 16'h0);
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL single_busy: got %b want 1", busy); end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'(i + 1));
    c8 = cyc;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0);
    checks++; if (s_cyc.size() - sb !== 1) begin errors++;
      $display("FAIL single_strobes: got %0d want 1", s_cyc.size() - sb); end
    if (s_cyc.size() - sb == 1) begin
      checks++; if (s_cyc[sb] !== c8) begin errors++;
        $display("FAIL single_latency: got cycle %0d want %0d", s_cyc[sb], c8); end
      checks++; if (s_dat[sb] !== exp) begin errors++;
        $display("FAIL single_data: got %h want %h", s_dat[sb], exp); end
    end
    checks++; if (hdr_data !== exp) begin errors++;
      $display("FAIL single_hold: got %h want %h", hdr_data, exp); end
  endtask

  task automatic test_full_frame();
    int sb, db, ab, c_last;
    logic prev_busy, busy_at_done, got_done;
    logic [127:0] exp;
    do_reset();
    sb = s_cyc.size(); db = d_cyc.size(); ab = a_cyc.size();
    step(1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 16'(16'h0100 + k));
    c_last = cyc;
    prev_busy = busy;
    got_done = 1'b0;
    busy_at_done = 1'bx;
    for (int t = 0; t < 12; t++) begin
      step(1'b0, 1'b0, 16'h0);
      if (frame_done === 1'b1) begin
        got_done = 1'b1;
        busy_at_done = busy;
        break;
      end
      prev_busy = busy;
    end
    checks++; if (got_done !== 1'b1) begin errors++;
      $display("FAIL frame_done_seen: got %b want 1 within 12 cycles", got_done); end
    checks++; if (busy_at_done !== 1'b0) begin errors++;
      $display("FAIL frame_busy_at_done: got %b want 0", busy_at_done); end
    checks++; if (prev_busy !== 1'b1) begin errors++;
      $display("FAIL frame_busy_before_done: got %b want 1", prev_busy); end
    checks++; if (s_cyc.size() - sb !== 4) begin errors++;
      $display("FAIL frame_strobes: got %0d want 4", s_cyc.size() - sb); end
    if (s_cyc.size() - sb == 4) begin
      for (int w = 0; w < 4; w++) begin
        for (int j = 0; j < 8; j++) exp[j*16 +: 16] = 16'(16'h0100 + 8 * w + j);
        checks++; if (s_dat[sb+w] !== exp) begin errors++;
          $display("FAIL frame_data%0d: got %h want %h", w, s_dat[sb+w], exp); end
        checks++; if (s_cyc[sb+w] !== c_last - 24 + 8 * w) begin errors++;
          $display("FAIL frame_strobe_cycle%0d: got %0d want %0d", w, s_cyc[sb+w],
                   c_last - 24 + 8 * w); end
      end
    end
    if (d_cyc.size() - db == 1) begin
      checks++; if (d_cyc[db] !== c_last + 4) begin errors++;
        $display("FAIL frame_done_delay: got cycle %0d want %0d", d_cyc[db], c_last + 4); end
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 16'(16'h0200 + k));
    for (int t = 0; t < 4; t++) step(1'b0, 1'b0, 16'h0);
    checks++; if (s_cyc.size() - sb !== 4) begin errors++;
      $display("FAIL frame_after_ignored: got %0d strobes want 4", s_cyc.size() - sb); end
    checks++; if (d_cyc.size() - db !== 1) begin errors++;
      $display("FAIL frame_done_count: got %0d want 1", d_cyc.size() - db); end
    checks++; if (a_cyc.size() - ab !== 0) begin errors++;
      $display("FAIL frame_no_abort: got %0d want 0", a_cyc.size() - ab); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL frame_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_gapped();
    int sb;
    logic [127:0] exp;
    do_reset();
    sb = s_cyc.size();
    step(1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 16'(16'h0A00 + k));
      step(1'b0, 1'b0, 16'h0);
    end
    checks++; if (s_cyc.size() - sb !== 2) begin errors++;
      $display("FAIL gapped_strobes: got %0d want 2", s_cyc.size() - sb); end
    if (s_cyc.size() - sb == 2) begin
      checks++; if (s_cyc[sb+1] - s_cyc[sb] !== 16) begin errors++;
        $display("FAIL gapped_spacing: got %0d want 16", s_cyc[sb+1] - s_cyc[sb]); end
      for (int w = 0; w < 2; w++) begin
        for (int j = 0; j < 8; j++) exp[j*16 +: 16] = 16'(16'h0A00 + 8 * w + j);
        checks++; if (s_dat[sb+w] !== exp) begin errors++;
          $display("FAIL gapped_data%0d: got %h want %h", w, s_dat[sb+w], exp); end
      end
    end
  endtask

  task automatic test_abort();
    int sb, ab, c_fs;
    logic [127:0] exp;
    do_reset();
    sb = s_cyc.size(); ab = a_cyc.size();
    step(1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 13; k++) step(1'b0, 1'b1, 16'(16'h0B00 + k));
    step(1'b1, 1'b0, 16'h0);
    c_fs = cyc;
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL abort_busy: got %b want 1", busy); end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 16'(16'h0C00 + k));
    step(1'b0, 1'b0, 16'h0);
    for (int j = 0; j < 8; j++) exp[j*16 +: 16] = 16'(16'h0C00 + j);
    checks++; if (s_cyc.size() - sb !== 2) begin errors++;
      $display("FAIL abort_strobes: got %0d want 2", s_cyc.size() - sb); end
    if (s_cyc.size() - sb == 2) begin
      checks++; if (s_dat[sb+1] !== exp) begin errors++;
        $display("FAIL abort_next_word: got %h want %h", s_dat[sb+1], exp); end
    end
    checks++; if (a_cyc.size() - ab !== 1) begin errors++;
      $display("FAIL abort_count: got %0d want 1", a_cyc.size() - ab); end
    if (a_cyc.size() - ab == 1) begin
      checks++; if (a_cyc[ab] !== c_fs) begin errors++;
        $display("FAIL abort_cycle: got %0d want %0d", a_cyc[ab], c_fs); end
    end
  endtask

  task automatic test_start_on_eighth();
    int sb, ab, c_fs, c_l;
    logic [127:0] exp;
    do_reset();
    sb = s_cyc.size(); ab = a_cyc.size();
    step(1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 16'(16'h0D00 + k));
    step(1'b1, 1'b1, 16'h0DEE);
    c_fs = cyc;
    for (int k = 1; k < 8; k++) step(1'b0, 1'b1, 16'(16'h0E00 + k));
    c_l = cyc;
    for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 16'h0);
    exp = 128'h0E07_0E06_0E05_0E04_0E03_0E02_0E01_0DEE;
    checks++; if (s_cyc.size() - sb !== 1) begin errors++;
      $display("FAIL coinc_strobes: got %0d want 1", s_cyc.size() - sb); end
    if (s_cyc.size() - sb == 1) begin
      checks++; if (s_dat[sb] !== exp) begin errors++;
        $display("FAIL coinc_data: got %h want %h", s_dat[sb], exp); end
      checks++; if (s_cyc[sb] !== c_l) begin errors++;
        $display("FAIL coinc_cycle: got %0d want %0d", s_cyc[sb], c_l); end
    end
    checks++; if (a_cyc.size() - ab !== 1) begin errors++;
      $display("FAIL coinc_abort: got %0d want 1", a_cyc.size() - ab); end
    if (a_cyc.size() - ab == 1) begin
      checks++; if (a_cyc[ab] !== c_fs) begin errors++;
        $display("FAIL coinc_abort_cycle: got %0d want %0d", a_cyc[ab], c_fs); end
    end
  endtask

  task automatic test_mid_reset();
    int sb, ab, db;
    logic [127:0] exp;
    do_reset();
    sb = s_cyc.size(); ab = a_cyc.size(); db = d_cyc.size();
    step(1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 16'(16'h0F00 + k));
    checks++; if (hdr_data === 128'h0) begin errors++;
      $display("FAIL mreset_pre_data: got %h want nonzero", hdr_data); end
    rst_25M = 1'b1;
    step(1'b0, 1'b1, 16'hFFFF);
    rst_25M = 1'b0;
    checks++; if (hdr_data !== 128'h0) begin errors++;
      $display("FAIL mreset_data: got %h want 0", hdr_data); end
    checks++; if ({hdr_data_valid, frame_done, frame_abort, busy} !== 4'b0) begin errors++;
      $display("FAIL mreset_flags: got %b want 0000",
               {hdr_data_valid, frame_done, frame_abort, busy}); end
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 16'(16'h0F80 + k));
    step(1'b0, 1'b0, 16'h0);
    checks++; if (s_cyc.size() - sb !== 1) begin errors++;
      $display("FAIL mreset_ignored: got %0d strobes want 1", s_cyc.size() - sb); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL mreset_idle: got %b want 0", busy); end
    step(1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 16'(16'h1000 + k));
    step(1'b0, 1'b0, 16'h0);
    for (int j = 0; j < 8; j++) exp[j*16 +: 16] = 16'(16'h1000 + j);
    checks++; if (s_cyc.size() - sb !== 2) begin errors++;
      $display("FAIL mreset_restart: got %0d strobes want 2", s_cyc.size() - sb); end
    if (s_cyc.size() - sb == 2) begin
      checks++; if (s_dat[sb+1] !== exp) begin errors++;
        $display("FAIL mreset_restart_data: got %h want %h", s_dat[sb+1], exp); end
    end
    checks++; if ((a_cyc.size() - ab) + (d_cyc.size() - db) !== 0) begin errors++;
      $display("FAIL mreset_no_pulses: got %0d abort/done pulses want 0",
               (a_cyc.size() - ab) + (d_cyc.size() - db)); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_frame();
    test_gapped();
    test_abort();
    test_start_on_eighth();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
